jtpopeye_objrom_ctrl: RTL and testbench



---
 rtl/jtpopeye_pkg.sv | 35 +++
 rtl/jtpopeye_objrom_ctrl_if.sv | 26 ++
 rtl/jtpopeye_objrom_tagpipe.sv | 43 ++++
 rtl/jtpopeye_objrom_ctrl.sv | 137 +++++++++++++
 tb/tb_jtpopeye_objrom_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/jtpopeye_pkg.sv
// rtl/jtpopeye_pkg.sv - shared constants and types for the Popeye object ROM bank
package jtpopeye_pkg;

    localparam int OBJ_AW = 13;

    localparam logic [1:0] PROM_1E = 2'd0;
    localparam logic [1:0] PROM_1F = 2'd1;
    localparam logic [1:0] PROM_1J = 2'd2;
    localparam logic [1:0] PROM_1K = 2'd3;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'd0,
        MODE_DL    = 2'd1,
        MODE_DRAIN = 2'd2
    } mode_e;

    typedef struct packed {
        logic vld;
        logic id;
    } tag_t;

    function automatic logic [3:0] prom_sel(input logic [1:0] idx);
        logic [3:0] sel;
        sel = 4'b0000;
        case (idx)
            PROM_1E: sel = 4'b0001;
            PROM_1F: sel = 4'b0010;
            PROM_1J: sel = 4'b0100;
            PROM_1K: sel = 4'b1000;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/jtpopeye_objrom_ctrl_if.sv
// rtl/jtpopeye_objrom_ctrl_if.sv - requester-side read port bundle of the object ROM controller
interface jtpopeye_objrom_ctrl_if;
    import jtpopeye_pkg::*;

    logic              req0;
    logic              req1;
    logic [OBJ_AW-1:0] addr0;
    logic [OBJ_AW-1:0] addr1;
    logic              ack0;
    logic              ack1;
    logic [31:0]       data0;
    logic [31:0]       data1;
    logic              valid0;
    logic              valid1;

    modport master (
        output req0, req1, addr0, addr1,
        input  ack0, ack1, data0, data1, valid0, valid1
    );

    modport slave (
        input  req0, req1, addr0, addr1,
        output ack0, ack1, data0, data1, valid0, valid1
    );

endinterface

// File: rtl/jtpopeye_objrom_tagpipe.sv
// rtl/jtpopeye_objrom_tagpipe.sv - {valid, id} shift register tracking reads in flight
module jtpopeye_objrom_tagpipe
    import jtpopeye_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  tag_t din,
    output tag_t dout
);

    tag_t pipe_q [DEPTH];
    tag_t pipe_d [DEPTH];

    always_comb begin
        pipe_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/jtpopeye_objrom_ctrl.sv
// rtl/jtpopeye_objrom_ctrl.sv - download steering and round-robin tagged read arbiter for the object ROMs
module jtpopeye_objrom_ctrl
    import jtpopeye_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     downloading,
    input  logic [15:0]              dl_addr,
    input  logic [7:0]               dl_data,
    input  logic                     dl_wr,
    output logic [14:0]              prog_addr,
    output logic [7:0]               prog_data,
    output logic [3:0]               prom_we,
    output logic [OBJ_AW-1:0]        obj_addr,
    input  logic [15:0]              obj_dout0,
    input  logic [15:0]              obj_dout1,
    jtpopeye_objrom_ctrl_if.slave    rd
);

    mode_e             mode;
    logic              dl_q,        dl_d;
    logic              last_q,      last_d;
    logic [14:0]       prog_addr_q, prog_addr_d;
    logic [7:0]        prog_data_q, prog_data_d;
    logic [3:0]        prom_we_q,   prom_we_d;
    logic [OBJ_AW-1:0] obj_addr_q,  obj_addr_d;
    logic [31:0]       data0_q,     data0_d;
    logic [31:0]       data1_q,     data1_d;
    logic              valid0_q,    valid0_d;
    logic              valid1_q,    valid1_d;
    logic              gnt0, gnt1;
    tag_t              tag_in, tag_out;

    // The cycle right after downloading drops is a dead cycle for the arbiter.
    always_comb begin
        if (downloading)  mode = MODE_DL;
        else if (dl_q)    mode = MODE_DRAIN;
        else              mode = MODE_RUN;
    end

    // On a tie the requester that was not served last wins.
    assign gnt0 = (mode == MODE_RUN) && rd.req0 && (!rd.req1 ||  last_q);
    assign gnt1 = (mode == MODE_RUN) && rd.req1 && (!rd.req0 || !last_q);

    always_comb begin
        tag_in     = '0;
        tag_in.vld = gnt0 | gnt1;
        tag_in.id  = gnt1;
    end

    jtpopeye_objrom_tagpipe #(
        .DEPTH (LAT)
    ) u_tagpipe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .din   (tag_in),
        .dout  (tag_out)
    );

    always_comb begin
        dl_d        = downloading;
        last_d      = last_q;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;
        prom_we_d   = 4'b0000;
        obj_addr_d  = obj_addr_q;
        data0_d     = data0_q;
        data1_d     = data1_q;
        valid0_d    = 1'b0;
        valid1_d    = 1'b0;

        if (mode == MODE_DL && dl_wr && !dl_addr[15]) begin
            prog_addr_d = dl_addr[14:0];
            prog_data_d = dl_data;
            prom_we_d   = prom_sel(dl_addr[14:13]);
        end

        if (gnt0) begin
            obj_addr_d = rd.addr0;
            last_d     = 1'b0;
        end else if (gnt1) begin
            obj_addr_d = rd.addr1;
            last_d     = 1'b1;
        end

        if (tag_out.vld) begin
            if (tag_out.id) begin
                data1_d  = {obj_dout0, obj_dout1};
                valid1_d = 1'b1;
            end else begin
                data0_d  = {obj_dout0, obj_dout1};
                valid0_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_q        <= 1'b0;
            last_q      <= 1'b1;
            prog_addr_q <= '0;
            prog_data_q <= '0;
            prom_we_q   <= '0;
            obj_addr_q  <= '0;
            data0_q     <= '0;
            data1_q     <= '0;
            valid0_q    <= 1'b0;
            valid1_q    <= 1'b0;
        end else begin
            dl_q        <= dl_d;
            last_q      <= last_d;
            prog_addr_q <= prog_addr_d;
            prog_data_q <= prog_data_d;
            prom_we_q   <= prom_we_d;
            obj_addr_q  <= obj_addr_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            valid0_q    <= valid0_d;
            valid1_q    <= valid1_d;
        end
    end

    assign prog_addr = prog_addr_q;
    assign prog_data = prog_data_q;
    assign prom_we   = prom_we_q;
    assign obj_addr  = obj_addr_q;
    assign rd.ack0   = gnt0;
    assign rd.ack1   = gnt1;
    assign rd.data0  = data0_q;
    assign rd.data1  = data1_q;
    assign rd.valid0 = valid0_q;
    assign rd.valid1 = valid1_q;

endmodule

// File: tb/tb_jtpopeye_objrom_ctrl.sv
// tb/tb_jtpopeye_objrom_ctrl.sv - directed self-checking bench for jtpopeye_objrom_ctrl
module tb_jtpopeye_objrom_ctrl;
    import jtpopeye_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              downloading;
    logic [15:0]       dl_addr;
    logic [7:0]        dl_data;
    logic              dl_wr;
    logic [14:0]       prog_addr;
    logic [7:0]        prog_data;
    logic [3:0]        prom_we;
    logic [OBJ_AW-1:0] obj_addr;
    logic [OBJ_AW-1:0] bank_a;
    logic [15:0]       obj_dout0;
    logic [15:0]       obj_dout1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] va   [5] = '{16'h0000, 16'h2005, 16'h4000, 16'h7FFF, 16'h8000};
    logic [7:0]  vd   [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [3:0]  vwe  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    logic [14:0] vpa  [5] = '{15'h0000, 15'h2005, 15'h4000, 15'h7FFF, 15'h7FFF};
    logic [7:0]  vpd  [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44};

    jtpopeye_objrom_ctrl_if rd_if ();

    jtpopeye_objrom_ctrl #(
        .LAT (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .dl_addr     (dl_addr),
        .dl_data     (dl_data),
        .dl_wr       (dl_wr),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prom_we     (prom_we),
        .obj_addr    (obj_addr),
        .obj_dout0   (obj_dout0),
        .obj_dout1   (obj_dout1),
        .rd          (rd_if)
    );

    always #5 clk = ~clk;

    // Bank model: one internal register after obj_addr, data readable LAT=2 cycles after the grant.
    always @(posedge clk) bank_a <= obj_addr;
    assign obj_dout0 = {3'b101, bank_a};
    assign obj_dout1 = {bank_a, 3'b011};

    function automatic logic [31:0] exp_word(input logic [12:0] a);
        return {3'b101, a, a, 3'b011};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic e_ack, e_val;
        logic [12:0] e_a;

        rst_n = 1'b0; downloading = 1'b0; dl_addr = '0; dl_data = '0; dl_wr = 1'b0;
        rd_if.req0 = 1'b0; rd_if.req1 = 1'b0; rd_if.addr0 = '0; rd_if.addr1 = '0;
        repeat (2) tick;
        @(negedge clk);
        check("rst_prog_addr", 32'(prog_addr), 32'h0);
        check("rst_prog_data", 32'(prog_data), 32'h0);
        check("rst_prom_we",   32'(prom_we),   32'h0);
        check("rst_obj_addr",  32'(obj_addr),  32'h0);
        check("rst_data0",     rd_if.data0,    32'h0);
        check("rst_data1",     rd_if.data1,    32'h0);
        check("rst_valid",     32'({rd_if.valid1, rd_if.valid0}), 32'h0);
        tick;
        rst_n = 1'b1;

        // Download steering, with requester 0 asking throughout.
        downloading = 1'b1;
        rd_if.req0 = 1'b1; rd_if.addr0 = 13'h055;
        for (int i = 0; i < 5; i++) begin
            tick;
            dl_wr = 1'b1; dl_addr = va[i]; dl_data = vd[i];
            @(negedge clk);
            check("dl_ack0", 32'(rd_if.ack0), 32'h0);
            tick;
            dl_wr = 1'b0;
            @(negedge clk);
            check("dl_prom_we",   32'(prom_we),   32'(vwe[i]));
            check("dl_prog_addr", 32'(prog_addr), 32'(vpa[i]));
            check("dl_prog_data", 32'(prog_data), 32'(vpd[i]));
            tick;
            @(negedge clk);
            check("dl_we_pulse", 32'(prom_we), 32'h0);
        end
        rd_if.req0 = 1'b0;
        tick;
        downloading = 1'b0;
        repeat (2) tick;

        // Download strobe outside download mode is dropped.
        dl_wr = 1'b1; dl_addr = 16'h0001; dl_data = 8'h99;
        tick;
        dl_wr = 1'b0;
        @(negedge clk);
        check("run_dlwr_we",   32'(prom_we),   32'h0);
        check("run_dlwr_addr", 32'(prog_addr), 32'h7FFF);

        // Single requester, back-to-back.
        for (int c = 0; c < 9; c++) begin
            tick;
            rd_if.req0  = (c < 4);
            rd_if.addr0 = 13'h100 + 13'(c);
            @(negedge clk);
            e_val = (c >= 3 && c <= 6);
            check("single_ack0",   32'(rd_if.ack0),   32'(c < 4));
            check("single_ack1",   32'(rd_if.ack1),   32'h0);
            check("single_valid0", 32'(rd_if.valid0), 32'(e_val));
            check("single_valid1", 32'(rd_if.valid1), 32'h0);
            if (e_val) check("single_data0", rd_if.data0, exp_word(13'h100 + 13'(c - 3)));
        end

        // Download rises with two reads in flight, then drain cycle, then a grant.
        for (int c = 0; c < 12; c++) begin
            tick;
            downloading = (c >= 2 && c <= 5);
            rd_if.req1  = (c <= 7);
            rd_if.addr1 = 13'h0A0 + 13'((c < 2) ? c : 2);
            @(negedge clk);
            e_ack = (c == 0 || c == 1 || c == 7);
            e_val = (c == 3 || c == 4 || c == 10);
            e_a   = (c == 3) ? 13'h0A0 : (c == 4) ? 13'h0A1 : 13'h0A2;
            check("dlmid_ack1",   32'(rd_if.ack1),   32'(e_ack));
            check("dlmid_ack0",   32'(rd_if.ack0),   32'h0);
            check("dlmid_valid1", 32'(rd_if.valid1), 32'(e_val));
            check("dlmid_valid0", 32'(rd_if.valid0), 32'h0);
            if (e_val) check("dlmid_data1", rd_if.data1, exp_word(e_a));
        end

        // Reset with reads in flight.
        for (int c = 0; c < 3; c++) begin
            tick;
            rd_if.req0  = 1'b1;
            rd_if.addr0 = 13'h200 + 13'(c);
            @(negedge clk);
            check("pre_rst_ack0", 32'(rd_if.ack0), 32'h1);
        end
        #1;
        rst_n = 1'b0;
        rd_if.req0 = 1'b0;
        tick;
        @(negedge clk);
        check("mid_rst_valid",     32'({rd_if.valid1, rd_if.valid0}), 32'h0);
        check("mid_rst_prog_addr", 32'(prog_addr), 32'h0);
        check("mid_rst_prog_data", 32'(prog_data), 32'h0);
        check("mid_rst_obj_addr",  32'(obj_addr),  32'h0);
        check("mid_rst_data0",     rd_if.data0,    32'h0);
        check("mid_rst_data1",     rd_if.data1,    32'h0);
        tick;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick;
            @(negedge clk);
            check("post_rst_valid", 32'({rd_if.valid1, rd_if.valid0}), 32'h0);
        end

        // Contention: acks alternate starting with requester 0.
        for (int c = 0; c < 10; c++) begin
            tick;
            rd_if.req0  = (c < 6);
            rd_if.req1  = (c < 6);
            rd_if.addr0 = 13'h300 + 13'((c + 1) / 2);
            rd_if.addr1 = 13'h400 + 13'(c / 2);
            @(negedge clk);
            check("cont_ack0", 32'(rd_if.ack0), 32'(c < 6 && (c % 2) == 0));
            check("cont_ack1", 32'(rd_if.ack1), 32'(c < 6 && (c % 2) == 1));
            e_val = (c == 3 || c == 5 || c == 7);
            check("cont_valid0", 32'(rd_if.valid0), 32'(e_val));
            if (e_val) check("cont_data0", rd_if.data0, exp_word(13'h300 + 13'((c - 3) / 2)));
            e_val = (c == 4 || c == 6 || c == 8);
            check("cont_valid1", 32'(rd_if.valid1), 32'(e_val));
            if (e_val) check("cont_data1", rd_if.data1, exp_word(13'h400 + 13'((c - 4) / 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
